// File: rtl/aes_key_expansion.sv
// -----------------------------------------------------------------------------
// aes_key_expansion
//
// Iterative AES-128 key schedule. A start pulse captures the cipher key into
// slot 0, then one round key per clock is derived into slots 1..10. The key
// selected by round_sel_in is presented combinationally once all 11 keys are
// valid; otherwise (or for an out-of-range index) the outputs read as zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_in              single-cycle expand request (ignored while busy)
//   key_0_in..key_3_in    cipher key words w[0]..w[3], byte 0 in [31:24]
//   round_sel_in          round key index 0..10
//   key_0_out..key_3_out  selected round key words, column 0 on key_0_out
//   busy_out              expansion in progress
//   key_ready_out         all 11 round keys valid
// -----------------------------------------------------------------------------
module aes_key_expansion #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] key_0_in,
    input  logic [DATA_WIDTH-1:0] key_1_in,
    input  logic [DATA_WIDTH-1:0] key_2_in,
    input  logic [DATA_WIDTH-1:0] key_3_in,
    input  logic [3:0]            round_sel_in,
    output logic [DATA_WIDTH-1:0] key_0_out,
    output logic [DATA_WIDTH-1:0] key_1_out,
    output logic [DATA_WIDTH-1:0] key_2_out,
    output logic [DATA_WIDTH-1:0] key_3_out,
    output logic                  busy_out,
    output logic                  key_ready_out
);

    localparam int unsigned KeyW     = 4 * DATA_WIDTH;
    localparam int unsigned NumSlots = 11;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StDone
    } state_e;

    // Four parallel forward S-box lookups.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      rc_q, rc_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [KeyW-1:0] rk_q [NumSlots];
    logic [KeyW-1:0] rk_d [NumSlots];

    logic [KeyW-1:0] prev_key;
    logic [KeyW-1:0] next_key;
    logic [KeyW-1:0] rd_key;
    logic [31:0]     temp;
    logic [31:0]     nw0, nw1, nw2, nw3;

    // Previous round key rk[rc-1]; rc is 1..10 while expanding.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < int'(NumSlots) - 1; i++) begin
            if (rc_q == 4'(i + 1)) prev_key = rk_q[i];
        end
    end

    // One key-schedule round: RotWord is {b1,b2,b3,b0}.
    always_comb begin
        temp     = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon_q, 24'h0};
        nw0      = prev_key[127:96] ^ temp;
        nw1      = prev_key[95:64] ^ nw0;
        nw2      = prev_key[63:32] ^ nw1;
        nw3      = prev_key[31:0] ^ nw2;
        next_key = {nw0, nw1, nw2, nw3};
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        rk_d    = rk_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_in) begin
                    rk_d[0] = {key_0_in, key_1_in, key_2_in, key_3_in};
                    rc_d    = 4'd1;
                    rcon_d  = 8'h01;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = StExpand;
                end
            end
            StExpand: begin
                for (int i = 1; i < int'(NumSlots); i++) begin
                    if (rc_q == 4'(i)) rk_d[i] = next_key;
                end
                // xtime in GF(2^8)
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                rc_d   = rc_q + 4'd1;
                if (rc_q == 4'd10) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rc_q    <= 4'd0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            for (int i = 0; i < int'(NumSlots); i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            for (int i = 0; i < int'(NumSlots); i++) rk_q[i] <= rk_d[i];
        end
    end

    // Zero-latency read port; indices 11..15 fall through to zero.
    always_comb begin
        rd_key = '0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            if (round_sel_in == 4'(i)) rd_key = rk_q[i];
        end
        if (!ready_q) rd_key = '0;
    end

    assign key_0_out     = rd_key[127:96];
    assign key_1_out     = rd_key[95:64];
    assign key_2_out     = rd_key[63:32];
    assign key_3_out     = rd_key[31:0];
    assign busy_out      = busy_q;
    assign key_ready_out = ready_q;

endmodule
